// File: rtl/hilo_control.sv
// HI/LO register file and multiply sequencer that sits after the MIPS multiplier.
// Issues operand magnitudes, waits out the multiplier latency, applies sign correction and captures the product.
module hilo_control #(
  parameter int WIDTH       = 32,
  parameter int MUL_LATENCY = 32
) (
  input  logic                 CLK,
  input  logic                 CLR_n,
  input  logic                 OpValid,
  input  logic [2:0]           Op,
  input  logic [WIDTH-1:0]     RsData,
  input  logic [WIDTH-1:0]     RtData,
  input  logic [2*WIDTH-1:0]   MulOut,
  output logic                 MulStart,
  output logic [WIDTH-1:0]     MulA,
  output logic [WIDTH-1:0]     MulB,
  output logic [WIDTH-1:0]     ReadData,
  output logic                 ReadValid,
  output logic                 Busy,
  output logic                 Stall
);

  localparam int CW = 8;

  typedef enum logic [1:0] {IDLE, RUN, CAPTURE} state_t;
  typedef enum logic [2:0] {
    OP_NONE  = 3'd0,
    OP_MULT  = 3'd1,
    OP_MULTU = 3'd2,
    OP_MTHI  = 3'd3,
    OP_MTLO  = 3'd4,
    OP_MFHI  = 3'd5,
    OP_MFLO  = 3'd6,
    OP_RSVD  = 3'd7
  } op_t;

  state_t           state;
  op_t              op_code;
  logic [CW-1:0]    count;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  logic             negate;

  logic             is_signed;
  logic [WIDTH-1:0] mag_a;
  logic [WIDTH-1:0] mag_b;
  logic             op_real;

  assign op_code   = op_t'(Op);
  assign op_real   = (op_code != OP_NONE) && (op_code != OP_RSVD);
  assign Stall     = OpValid && Busy && op_real;

  // MULT feeds the unsigned multiplier absolute values; the most negative value maps onto itself.
  assign is_signed = (op_code == OP_MULT);
  assign mag_a     = (is_signed && RsData[WIDTH-1]) ? -RsData : RsData;
  assign mag_b     = (is_signed && RtData[WIDTH-1]) ? -RtData : RtData;

  // NOTE: every register here is sequential state, so all assignments are non-blocking.
  always_ff @(posedge CLK or negedge CLR_n) begin
    if (!CLR_n) begin
      // NOTE: HI/LO are architectural state, not bulk storage, so they are reset with everything else.
      state     <= IDLE;
      count     <= '0;
      hi        <= '0;
      lo        <= '0;
      negate    <= 1'b0;
      MulStart  <= 1'b0;
      MulA      <= '0;
      MulB      <= '0;
      ReadData  <= '0;
      ReadValid <= 1'b0;
      Busy      <= 1'b0;
    end else begin
      MulStart  <= 1'b0;
      ReadValid <= 1'b0;
      case (state)
        IDLE: begin
          if (OpValid) begin
            case (op_code)
              OP_MULT, OP_MULTU: begin
                MulA     <= mag_a;
                MulB     <= mag_b;
                negate   <= is_signed && (RsData[WIDTH-1] ^ RtData[WIDTH-1]);
                count    <= CW'(MUL_LATENCY);
                MulStart <= 1'b1;
                Busy     <= 1'b1;
                state    <= RUN;
              end
              OP_MTHI: hi <= RsData;
              OP_MTLO: lo <= RsData;
              OP_MFHI: begin
                ReadData  <= hi;
                ReadValid <= 1'b1;
              end
              OP_MFLO: begin
                ReadData  <= lo;
                ReadValid <= 1'b1;
              end
              default: ;
            endcase
          end
        end
        RUN: begin
          count <= count - CW'(1);
          if (count == CW'(1)) state <= CAPTURE;
        end
        CAPTURE: begin
          {hi, lo} <= negate ? -MulOut : MulOut;
          Busy     <= 1'b0;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_hilo_control.sv
// Randomised and directed bench for hilo_control against a signed/unsigned arithmetic HI/LO model.
// A behavioural multiplier drives garbage on MulOut until its latency has elapsed.
module tb_hilo_control;

  localparam int WIDTH = 32;
  localparam int L     = 32;

  localparam logic [2:0] OP_NONE  = 3'd0, OP_MULT = 3'd1, OP_MULTU = 3'd2, OP_MTHI = 3'd3,
                         OP_MTLO  = 3'd4, OP_MFHI = 3'd5, OP_MFLO  = 3'd6, OP_RSVD = 3'd7;

  logic                 CLK;
  logic                 CLR_n;
  logic                 OpValid;
  logic [2:0]           Op;
  logic [WIDTH-1:0]     RsData;
  logic [WIDTH-1:0]     RtData;
  logic [2*WIDTH-1:0]   MulOut;
  logic                 MulStart;
  logic [WIDTH-1:0]     MulA;
  logic [WIDTH-1:0]     MulB;
  logic [WIDTH-1:0]     ReadData;
  logic                 ReadValid;
  logic                 Busy;
  logic                 Stall;

  hilo_control #(.WIDTH(WIDTH), .MUL_LATENCY(L)) dut (
    .CLK(CLK), .CLR_n(CLR_n), .OpValid(OpValid), .Op(Op), .RsData(RsData), .RtData(RtData),
    .MulOut(MulOut), .MulStart(MulStart), .MulA(MulA), .MulB(MulB), .ReadData(ReadData),
    .ReadValid(ReadValid), .Busy(Busy), .Stall(Stall)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  int cyc = 0;
  always @(posedge CLK) cyc++;

  // Behavioural multiplier: the true product appears only once MUL_LATENCY edges have passed since the start pulse.
  int          mrem = 0;
  logic [63:0] mprod;
  always @(negedge CLK) begin
    if (!CLR_n) begin
      mrem   = 0;
      MulOut = {$urandom, $urandom};
    end else if (MulStart) begin
      mprod  = {32'b0, MulA} * {32'b0, MulB};
      mrem   = L;
      MulOut = {$urandom, $urandom};
    end else if (mrem > 0) begin
      mrem--;
      MulOut = (mrem == 0) ? mprod : {$urandom, $urandom};
    end
  end

  int          n_checks = 0;
  int          n_pass   = 0;
  logic [31:0] ref_hi   = '0;
  logic [31:0] ref_lo   = '0;
  int          busy_end = -1000;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    else n_pass++;
  endtask

  function automatic logic [31:0] mag(input logic [31:0] v, input bit sgn);
    return (sgn && v[31]) ? 32'(0) - v : v;
  endfunction

  // Present an op just after a rising edge, hold it through any stall, and check the accepted result.
  task automatic issue(input logic [2:0] op, input logic [31:0] rs, input logic [31:0] rt);
    int          first_edge;
    int          stalls;
    int          exp_stalls;
    bit          real_op;
    logic [63:0] prod;
    OpValid    = 1'b1;
    Op         = op;
    RsData     = rs;
    RtData     = rt;
    first_edge = cyc + 1;
    stalls     = 0;
    @(negedge CLK);
    while (Stall && stalls <= 1000) begin
      stalls++;
      @(negedge CLK);
    end
    real_op    = (op != OP_NONE) && (op != OP_RSVD);
    exp_stalls = (real_op && busy_end >= first_edge) ? busy_end - first_edge + 1 : 0;
    check("stall_cycles", stalls, exp_stalls);
    @(posedge CLK);
    #1;
    case (op)
      OP_MULT, OP_MULTU: begin
        check("mulstart", MulStart, 1'b1);
        check("busy_set", Busy, 1'b1);
        check("mul_a", MulA, mag(rs, op == OP_MULT));
        check("mul_b", MulB, mag(rt, op == OP_MULT));
        if (op == OP_MULT) prod = 64'(longint'($signed(rs)) * longint'($signed(rt)));
        else               prod = {32'b0, rs} * {32'b0, rt};
        {ref_hi, ref_lo} = prod;
        busy_end = cyc + L + 1;
      end
      OP_MTHI: ref_hi = rs;
      OP_MTLO: ref_lo = rs;
      OP_MFHI, OP_MFLO: begin
        check("read_valid", ReadValid, 1'b1);
        check((op == OP_MFHI) ? "read_hi" : "read_lo", ReadData, (op == OP_MFHI) ? ref_hi : ref_lo);
      end
      default: check("no_read_strobe", ReadValid, 1'b0);
    endcase
    if (op == OP_MTHI || op == OP_MTLO) check("no_read_strobe", ReadValid, 1'b0);
    OpValid = 1'b0;
  endtask

  // Starting one step after the accept edge, count how many sampled cycles Busy stays high.
  task automatic wait_idle(input bit check_len);
    int busy_n = 0;
    int starts = 0;
    int guard  = 0;
    while (Busy && guard < 1000) begin
      busy_n++;
      @(posedge CLK);
      #1;
      guard++;
      if (MulStart) starts++;
    end
    check("idle_reached", Busy, 1'b0);
    if (check_len) begin
      check("busy_len", busy_n, L + 1);
      check("extra_start", starts, 0);
    end
  endtask

  function automatic logic [31:0] pick_operand();
    case ($urandom_range(0, 5))
      0: return 32'h0000_0000;
      1: return 32'h0000_0001;
      2: return 32'h8000_0000;
      3: return 32'hFFFF_FFFF;
      4: return 32'h7FFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    CLR_n   = 1'b0;
    OpValid = 1'b0;
    Op      = OP_NONE;
    RsData  = '0;
    RtData  = '0;
    #12;
    OpValid = 1'b1;
    Op      = OP_MULT;
    #1;
    check("rst_busy", Busy, 1'b0);
    check("rst_stall", Stall, 1'b0);
    check("rst_mulstart", MulStart, 1'b0);
    check("rst_mula", MulA, '0);
    check("rst_mulb", MulB, '0);
    check("rst_readdata", ReadData, '0);
    check("rst_readvalid", ReadValid, 1'b0);
    OpValid = 1'b0;
    @(negedge CLK);
    CLR_n = 1'b1;
    @(posedge CLK);
    #1;

    issue(OP_MFHI, '0, '0);
    issue(OP_MFLO, '0, '0);

    // Unsigned multiply: single start pulse, Busy for L+1 edges, then read back.
    issue(OP_MULTU, 32'h0000_007F, 32'h0000_0070);
    wait_idle(1'b1);
    issue(OP_MFHI, '0, '0);
    issue(OP_MFLO, '0, '0);
    check("multu_lo_const", ReadData, 32'h0000_3790);

    issue(OP_MULT, 32'hFFFF_FFFF, 32'h0000_0001);
    wait_idle(1'b1);
    issue(OP_MFHI, '0, '0);
    issue(OP_MFLO, '0, '0);

    issue(OP_MULT, 32'h8000_0000, 32'h8000_0000);
    wait_idle(1'b1);
    issue(OP_MFHI, '0, '0);
    check("min_sq_hi_const", ReadData, 32'h4000_0000);
    issue(OP_MFLO, '0, '0);

    // Read held under stall from 3 cycles after the multiply is accepted.
    issue(OP_MULTU, 32'h0000_007F, 32'h0000_0070);
    repeat (2) @(posedge CLK);
    #1;
    issue(OP_MFLO, '0, '0);
    @(posedge CLK);
    #1;
    check("read_pulse_once", ReadValid, 1'b0);

    issue(OP_MTHI, 32'hDEAD_BEEF, '0);
    issue(OP_MFHI, '0, '0);
    issue(OP_MTLO, 32'h1234_5678, '0);
    issue(OP_MFLO, '0, '0);

    // Back-to-back multiplies: the second stalls until the first has captured.
    issue(OP_MULT, 32'hFFFF_FFF9, 32'h0000_0003);
    issue(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    wait_idle(1'b1);
    issue(OP_MFHI, '0, '0);
    issue(OP_MFLO, '0, '0);

    // Reset in flight discards the product.
    issue(OP_MULTU, 32'h0000_1234, 32'h0000_5678);
    repeat (10) @(posedge CLK);
    #2;
    OpValid = 1'b1;
    Op      = OP_MFLO;
    CLR_n   = 1'b0;
    #1;
    check("midrst_busy", Busy, 1'b0);
    check("midrst_stall", Stall, 1'b0);
    check("midrst_mulstart", MulStart, 1'b0);
    check("midrst_mula", MulA, '0);
    OpValid = 1'b0;
    @(negedge CLK);
    CLR_n    = 1'b1;
    ref_hi   = '0;
    ref_lo   = '0;
    busy_end = -1000;
    @(posedge CLK);
    #1;
    issue(OP_MFLO, '0, '0);
    issue(OP_MFHI, '0, '0);

    for (int i = 0; i < 60; i++) begin
      issue(3'($urandom_range(0, 7)), pick_operand(), pick_operand());
    end
    wait_idle(1'b0);
    issue(OP_MFHI, '0, '0);
    issue(OP_MFLO, '0, '0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
